// File: rtl/keccak_pkg.sv
// -----------------------------------------------------------------------------
// keccak_pkg
// Shared definitions for the Keccak squeeze/output path:
//   - mode encodings (SHA3-512, SHA3-256, SHAKE128, SHAKE256)
//   - output FSM state encodings
//   - RATE_WORDS[mode]   : 64-bit rate words per permutation block
//   - DIGEST_BYTES[mode] : fixed digest length (0 for the XOF modes)
//   - keep_mask(n)       : byte-enable mask with the top n bits set
// No ports; imported by keccak_out_shreg and keccak_squeeze_out.
// -----------------------------------------------------------------------------
package keccak_pkg;

  localparam int WORD_W      = 64;
  localparam int STATE_W     = 1600;
  // Widest rate (SHAKE128) is 21 lanes; narrower modes just never read the tail.
  localparam int MAX_WORDS   = 21;
  localparam int RATE_MAX_W  = MAX_WORDS * WORD_W;   // 1344

  localparam logic [1:0] MODE_SHA3_512 = 2'd0;
  localparam logic [1:0] MODE_SHA3_256 = 2'd1;
  localparam logic [1:0] MODE_SHAKE128 = 2'd2;
  localparam logic [1:0] MODE_SHAKE256 = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_SQZ    = 2'd3;

  // Indexed directly by the 2-bit mode.
  localparam logic [4:0] RATE_WORDS   [0:3] = '{5'd9, 5'd17, 5'd21, 5'd17};
  localparam logic [6:0] DIGEST_BYTES [0:3] = '{7'd64, 7'd32, 7'd0, 7'd0};

  // SHAKE modes take their length from the caller instead of the table.
  function automatic logic is_xof(input logic [1:0] m);
    return m[1];
  endfunction

  // Byte 0 lives in bit 7, so a partial word keeps its leading bytes.
  // n is saturated to 8 by the caller; n >= 8 gives 8'hFF.
  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [7:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < n) m[7-b] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/keccak_out_shreg.sv
// -----------------------------------------------------------------------------
// keccak_out_shreg
// Holds the rate portion of one permutation output and presents it one
// 64-bit lane at a time, most significant lane first. A word counter tracks
// how many lanes of the current block remain.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (counter only)
//   load         : capture load_data and load_words
//   load_data    : top 1344 bits of the Keccak state
//   load_words   : lanes in this block (rate of the active mode)
//   shift        : advance to the next lane (current word consumed)
//   word         : current lane
//   last_word    : current lane is the final one of the block
// -----------------------------------------------------------------------------
module keccak_out_shreg
  import keccak_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [RATE_MAX_W-1:0] load_data,
  input  logic [4:0]            load_words,
  input  logic                  shift,
  output logic [WORD_W-1:0]     word,
  output logic                  last_word
);

  logic [RATE_MAX_W-1:0] data_q, data_d;
  logic [4:0]            cnt_q,  cnt_d;

  // NOTE: every combinational output gets a default before the if-chain, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data;
      cnt_d  = load_words;
    end else if (shift) begin
      data_d = {data_q[RATE_MAX_W-WORD_W-1:0], {WORD_W{1'b0}}};
      cnt_d  = cnt_q - 5'd1;
    end
  end

  // NOTE: the wide data register has no reset; it is always loaded before it
  // is read, and the top gates dout with dout_valid so reset still shows 0.
  // Sequential state uses non-blocking assignments so all flops update
  // together at the edge regardless of block evaluation order.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign word      = data_q[RATE_MAX_W-1 -: WORD_W];
  assign last_word = (cnt_q == 5'd1);

endmodule

// File: rtl/keccak_squeeze_out.sv
// -----------------------------------------------------------------------------
// keccak_squeeze_out
// Squeeze side of the Keccak core. After start, waits for f_permutation to
// present a state, captures the rate lanes (pulsing pack to release the
// state), and streams them to the host as 64-bit words. In SHAKE modes it
// pulses squeeze for further permutations until out_len bytes are delivered.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   mode                  : 0 SHA3-512, 1 SHA3-256, 2 SHAKE128, 3 SHAKE256
//   start                 : begin output; latches mode and out_len
//   out_len               : XOF output length in bytes (modes 2/3)
//   state_in, state_ready : permutation result and its valid flag
//   pack                  : 1-cycle pulse, state captured
//   squeeze               : 1-cycle pulse, request another permutation
//   dout, dout_keep,
//   dout_valid, dout_last,
//   dout_ready            : host word stream (byte 0 in dout[63:56])
//   busy                  : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module keccak_squeeze_out
  import keccak_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic [LEN_W-1:0]   out_len,
  input  logic [STATE_W-1:0] state_in,
  input  logic               state_ready,
  output logic               pack,
  output logic               squeeze,
  output logic [WORD_W-1:0]  dout,
  output logic [7:0]         dout_keep,
  output logic               dout_valid,
  output logic               dout_last,
  input  logic               dout_ready,
  output logic               busy
);

  localparam logic [LEN_W-1:0] WORD_BYTES = LEN_W'(8);

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q,  mode_d;
  logic [LEN_W-1:0] rem_q,   rem_d;

  logic             sh_load;
  logic             sh_shift;
  logic [WORD_W-1:0] sh_word;
  logic             sh_last_word;
  logic             rem_final;
  logic [3:0]       rem_small;

  // Capacity lanes never leave the core.
  logic unused_capacity;
  assign unused_capacity = ^state_in[STATE_W-RATE_MAX_W-1:0];

  keccak_out_shreg u_shreg (
    .clk        (clk),
    .reset      (reset),
    .load       (sh_load),
    .load_data  (state_in[STATE_W-1 -: RATE_MAX_W]),
    .load_words (RATE_WORDS[mode_q]),
    .shift      (sh_shift),
    .word       (sh_word),
    .last_word  (sh_last_word)
  );

  // The word being presented carries the tail of the output.
  assign rem_final = (rem_q <= WORD_BYTES);
  assign rem_small = rem_final ? rem_q[3:0] : 4'd8;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A zero-length XOF request has nothing to deliver; drop it.
        if (start && !(is_xof(mode) && out_len == '0)) begin
          mode_d  = mode;
          rem_d   = is_xof(mode) ? out_len : LEN_W'(DIGEST_BYTES[mode]);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (state_ready) begin
          sh_load = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (dout_ready) begin
          sh_shift = 1'b1;
          if (rem_final) begin
            rem_d   = '0;
            state_d = ST_IDLE;
          end else begin
            rem_d   = rem_q - WORD_BYTES;
            // Block drained but bytes still owed: ask for another permutation.
            state_d = sh_last_word ? ST_SQZ : ST_STREAM;
          end
        end
      end
      ST_SQZ: begin
        state_d = ST_WAIT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SHA3_512;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  // pack coincides with the capture, so f_permutation may drop out_ready
  // on the very next cycle.
  assign pack       = (state_q == ST_WAIT) && state_ready;
  assign squeeze    = (state_q == ST_SQZ);
  assign dout_valid = (state_q == ST_STREAM);
  assign busy       = (state_q != ST_IDLE);

  // Word content is held in the register while stalled, so these stay
  // stable until the handshake.
  assign dout      = dout_valid ? sh_word : '0;
  assign dout_keep = dout_valid ? keep_mask(rem_small) : 8'h00;
  assign dout_last = dout_valid && rem_final;

endmodule

// File: tb/tb_keccak_squeeze_out.sv
module tb_keccak_squeeze_out;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic          start;
  logic [15:0]   out_len;
  logic [1599:0] state_in;
  logic          state_ready;
  logic          pack;
  logic          squeeze;
  logic [63:0]   dout;
  logic [7:0]    dout_keep;
  logic          dout_valid;
  logic          dout_last;
  logic          dout_ready;
  logic          busy;

  always #5 clk = ~clk;

  keccak_squeeze_out #(.LEN_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .start       (start),
    .out_len     (out_len),
    .state_in    (state_in),
    .state_ready (state_ready),
    .pack        (pack),
    .squeeze     (squeeze),
    .dout        (dout),
    .dout_keep   (dout_keep),
    .dout_valid  (dout_valid),
    .dout_last   (dout_last),
    .dout_ready  (dout_ready),
    .busy        (busy)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int words_seen = 0;
  int pack_cnt = 0;
  int sqz_cnt = 0;
  int overlap_cnt = 0;
  logic toggle_en = 1'b0;
  logic [1599:0] next_state;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] word_val(input logic [7:0] seed, input int w);
    logic [31:0] lo;
    lo = 32'hDEADBEEF ^ (32'(w) * 32'h01010101);
    return {seed, 8'(w), 16'hC35A, lo};
  endfunction

  function automatic logic [1599:0] mk_state(input logic [7:0] seed);
    logic [1599:0] s;
    s = '0;
    for (int w = 0; w < 25; w++) s[1599-64*w -: 64] = word_val(seed, w);
    return s;
  endfunction

  function automatic logic [7:0] kmask(input int rem);
    logic [7:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) m[7-b] = (b < rem);
    return m;
  endfunction

  // Expected word stream: block A lanes in order, then block B after a squeeze.
  task automatic push_expected(input int md, input int len, input logic [7:0] seed_a,
                               input logic [7:0] seed_b);
    int rate, rem, k;
    logic [7:0] blk;
    beat_t e;
    case (md)
      0: begin rate = 9;  rem = 64;  end
      1: begin rate = 17; rem = 32;  end
      2: begin rate = 21; rem = len; end
      default: begin rate = 17; rem = len; end
    endcase
    k = 0;
    blk = seed_a;
    while (rem > 0) begin
      e.d = word_val(blk, k);
      e.k = kmask(rem);
      e.l = (rem <= 8);
      exp_q.push_back(e);
      rem -= (rem > 8) ? 8 : rem;
      k++;
      if (k == rate && rem > 0) begin
        k = 0;
        blk = seed_b;
      end
    end
  endtask

  task automatic do_start(input logic [1:0] md, input logic [15:0] len);
    @(negedge clk);
    mode = md;
    out_len = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 dout_ready = v;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    check(name, busy, 0);
  endtask

  // Scoreboard monitor and stall-stability checker.
  initial begin
    logic        stall_prev;
    logic [63:0] sd;
    logic [7:0]  sk;
    logic        sl;
    stall_prev = 1'b0;
    sd = '0; sk = '0; sl = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && stall_prev) begin
        check("stall_valid", dout_valid, 1);
        check("stall_dout", dout, sd);
        check("stall_keep", dout_keep, sk);
        check("stall_last", dout_last, sl);
      end
      if (!reset && dout_valid && dout_ready) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%h expected=none", dout);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("word_dout", dout, e.d);
          check("word_keep", dout_keep, e.k);
          check("word_last", dout_last, e.l);
        end
      end
      stall_prev = dout_valid && !dout_ready && !reset;
      sd = dout;
      sk = dout_keep;
      sl = dout_last;
      if (pack && squeeze) overlap_cnt++;
    end
  end

  // f_permutation stand-in: drops out_ready after pack, re-raises it with
  // next_state a few cycles after squeeze.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && pack) begin
        pack_cnt++;
        @(posedge clk);
        #1 state_ready = 1'b0;
      end else if (!reset && squeeze) begin
        sqz_cnt++;
        repeat (3) @(posedge clk);
        #1;
        state_in = next_state;
        state_ready = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) dout_ready = ~dout_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0, w0;
    logic busy_seen, valid_seen;
    reset = 1'b1;
    mode = 2'd0;
    start = 1'b0;
    out_len = '0;
    state_in = '0;
    state_ready = 1'b0;
    dout_ready = 1'b0;
    next_state = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pack", pack, 0);
    check("rst_squeeze", squeeze, 0);
    check("rst_dout", dout, 0);
    check("rst_keep", dout_keep, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_last", dout_last, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    // SHA3-256, state already ready, host always ready
    state_in = mk_state(8'h01);
    state_ready = 1'b1;
    dout_ready = 1'b1;
    p0 = pack_cnt; s0 = sqz_cnt; w0 = words_seen;
    push_expected(1, 0, 8'h01, 8'h01);
    do_start(2'd1, 16'd0);
    check("lat_pack", pack, 1);
    check("lat_valid_early", dout_valid, 0);
    @(negedge clk);
    check("lat_valid", dout_valid, 1);
    wait_idle("m1_idle");
    check("m1_packs", pack_cnt - p0, 1);
    check("m1_squeezes", sqz_cnt - s0, 0);
    check("m1_words", words_seen - w0, 4);
    check("m1_drained", exp_q.size(), 0);

    // SHA3-512 with host stalling every other cycle
    state_in = mk_state(8'h02);
    state_ready = 1'b1;
    p0 = pack_cnt; w0 = words_seen;
    push_expected(0, 0, 8'h02, 8'h02);
    toggle_en = 1'b1;
    do_start(2'd0, 16'd0);
    wait_idle("m0_idle");
    toggle_en = 1'b0;
    set_ready(1'b1);
    check("m0_packs", pack_cnt - p0, 1);
    check("m0_words", words_seen - w0, 8);
    check("m0_drained", exp_q.size(), 0);

    // SHAKE128, 170 bytes: one full block, squeeze, two-byte tail
    state_in = mk_state(8'h03);
    next_state = mk_state(8'h04);
    state_ready = 1'b1;
    p0 = pack_cnt; s0 = sqz_cnt; w0 = words_seen;
    push_expected(2, 170, 8'h03, 8'h04);
    do_start(2'd2, 16'd170);
    wait_idle("m2_idle");
    check("m2_packs", pack_cnt - p0, 2);
    check("m2_squeezes", sqz_cnt - s0, 1);
    check("m2_words", words_seen - w0, 22);
    check("m2_drained", exp_q.size(), 0);

    // SHAKE256, 5 bytes: single partial word
    state_in = mk_state(8'h05);
    state_ready = 1'b1;
    p0 = pack_cnt; s0 = sqz_cnt; w0 = words_seen;
    push_expected(3, 5, 8'h05, 8'h05);
    do_start(2'd3, 16'd5);
    wait_idle("m3_idle");
    check("m3_packs", pack_cnt - p0, 1);
    check("m3_squeezes", sqz_cnt - s0, 0);
    check("m3_words", words_seen - w0, 1);

    // start while busy is ignored
    state_in = mk_state(8'h06);
    state_ready = 1'b1;
    set_ready(1'b0);
    p0 = pack_cnt; w0 = words_seen;
    push_expected(1, 0, 8'h06, 8'h06);
    do_start(2'd1, 16'd0);
    repeat (3) @(negedge clk);
    check("busy_hold_busy", busy, 1);
    check("busy_hold_valid", dout_valid, 1);
    do_start(2'd0, 16'd0);
    repeat (2) @(negedge clk);
    set_ready(1'b1);
    wait_idle("busy_idle");
    check("busy_packs", pack_cnt - p0, 1);
    check("busy_words", words_seen - w0, 4);
    check("busy_drained", exp_q.size(), 0);

    // Reset in the middle of streaming
    state_in = mk_state(8'h07);
    state_ready = 1'b1;
    set_ready(1'b0);
    do_start(2'd1, 16'd0);
    for (int i = 0; i < 20 && !dout_valid; i++) @(negedge clk);
    check("rst_mid_pre_valid", dout_valid, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_valid", dout_valid, 0);
    check("rst_mid_pack", pack, 0);
    check("rst_mid_squeeze", squeeze, 0);
    check("rst_mid_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    dout_ready = 1'b1;

    // SHAKE128 with zero length: no activity
    state_in = mk_state(8'h08);
    state_ready = 1'b1;
    p0 = pack_cnt; w0 = words_seen;
    busy_seen = 1'b0;
    valid_seen = 1'b0;
    do_start(2'd2, 16'd0);
    for (int i = 0; i < 6; i++) begin
      busy_seen  |= busy;
      valid_seen |= dout_valid;
      @(negedge clk);
    end
    check("zero_busy", busy_seen, 0);
    check("zero_valid", valid_seen, 0);
    check("zero_packs", pack_cnt - p0, 0);
    check("zero_words", words_seen - w0, 0);

    check("pack_squeeze_overlap", overlap_cnt, 0);
    check("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
